// File: rtl/avalon_mm_mult_csr.sv
// avalon_mm_mult_csr: Avalon-MM CSR slave around a sequential shift-add multiplier.
//   Ports: clk, rst (async, active-high), addr/read/write/write_data (request),
//   read_data/readdatavalid (1-cycle read response), waitrequest (stall),
//   irq (only when MULT_CSR_IRQ_EN is defined: done AND irq_en, registered).
//   Map (NA=SZ/DW): 0 CTRL, 1 STATUS, 2.. A words, 2+NA.. B words, 2+2NA.. RES words.
module avalon_mm_mult_csr #(
    parameter int SZ = 32,
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic          read,
    input  logic          write,
    input  logic [DW-1:0] write_data,
    output logic [DW-1:0] read_data,
    output logic          readdatavalid,
    output logic          waitrequest
`ifdef MULT_CSR_IRQ_EN
    ,
    output logic          irq
`endif
);
    localparam int NA = SZ / DW;
    localparam int CW = $clog2(SZ);
    localparam logic [AW-1:0] A0 = AW'(2);
    localparam logic [AW-1:0] B0 = AW'(2 + NA);
    localparam logic [AW-1:0] R0 = AW'(2 + 2 * NA);
    localparam logic [AW-1:0] RE = AW'(1 + 4 * NA);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_n;

    logic [NA-1:0][DW-1:0]   a, b;
    logic [2*NA-1:0][DW-1:0] res;
    logic [2*SZ-1:0]         acc, acc_n, mcand;
    logic [SZ-1:0]           mplier;
    logic [CW-1:0]           cnt;
    logic                    busy, done, err, irq_en;
    logic                    accept, rd_acc, wr_acc, ctrl_wr, start, fin;
    logic [DW-1:0]           rd_mux;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy    = state == RUN;
        // Operand/result words stall while running; CTRL and STATUS never do.
        waitrequest = busy && (read || write) && addr >= A0 && addr <= RE;
        accept  = (read || write) && !waitrequest;
        rd_acc  = accept && read;
        // A simultaneous read wins; the write is dropped.
        wr_acc  = accept && write && !read;
        ctrl_wr = wr_acc && addr == '0;
        start   = ctrl_wr && write_data[0] && !busy;
        fin     = busy && cnt == '0;
        acc_n   = acc + (mplier[0] ? mcand : '0);
        if (start) state_n = RUN;
        else if (fin) state_n = IDLE;
    end

    always_comb begin
        rd_mux = '0;
        if (addr == AW'(1)) rd_mux = {{(DW-4){1'b0}}, irq_en, err, done, busy};
        for (int i = 0; i < NA; i++) begin
            if (addr == A0 + AW'(i)) rd_mux = a[i];
            if (addr == B0 + AW'(i)) rd_mux = b[i];
        end
        for (int i = 0; i < 2 * NA; i++)
            if (addr == R0 + AW'(i)) rd_mux = res[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data     <= '0;
            readdatavalid <= 1'b0;
            a             <= '0;
            b             <= '0;
            res           <= '0;
            acc           <= '0;
            mcand         <= '0;
            mplier        <= '0;
            cnt           <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            irq_en        <= 1'b0;
`ifdef MULT_CSR_IRQ_EN
            irq           <= 1'b0;
`endif
        end else begin
            readdatavalid <= rd_acc;
            if (rd_acc) read_data <= rd_mux;
            for (int i = 0; i < NA; i++) begin
                if (wr_acc && addr == A0 + AW'(i)) a[i] <= write_data;
                if (wr_acc && addr == B0 + AW'(i)) b[i] <= write_data;
            end
            if (busy) begin
                acc    <= acc_n;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - 1'b1;
                if (fin) begin
                    res  <= acc_n;
                    done <= 1'b1;
                end
            end
            if (start) begin
                acc    <= '0;
                mcand  <= {{SZ{1'b0}}, a};
                mplier <= b;
                cnt    <= CW'(SZ - 1);
            end
            // CTRL processed after completion so an explicit clear wins; start follows the clear.
            if (ctrl_wr) begin
                irq_en <= write_data[2];
                if (write_data[1]) begin
                    done <= 1'b0;
                    err  <= 1'b0;
                end
                if (write_data[0]) begin
                    if (busy) err <= 1'b1;
                    else      done <= 1'b0;
                end
            end
`ifdef MULT_CSR_IRQ_EN
            // Drop on the very edge that clears done or irq_en.
            irq <= done && irq_en && !(ctrl_wr && (write_data[1] || !write_data[2] || start));
`endif
        end
    end
endmodule

// File: doc/avalon_mm_mult_csr.md
Name: avalon_mm_mult_csr

Overview:
Parametrised Avalon-MM slave that wraps an internal sequential shift-add multiplier behind a word-addressed CSR map. It is the successor to the fixed 32-bit/16-bit multiplier slave. It adds configurable operand and bus widths, explicit start/done control, waitrequest stalling and pipelined reads with readdatavalid. It sits on the Avalon-MM interconnect beside the AXI4 variant for the protocol comparison.

Parameters:
SZ, 32, operand width in bits; must be a multiple of DW and at least DW
DW, 16, bus data width (16 or 32)
AW, 4, word address width; must satisfy 2^AW >= 2 + 4*(SZ/DW)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
addr  in  AW  word address
read  in  1  read request
write  in  1  write request
write_data  in  DW  write data
read_data  out  DW  read data, valid when readdatavalid=1
readdatavalid  out  1  read response strobe
waitrequest  out  1  stall; the master holds the request while this is 1

Behaviour:
- Address map, with NA=SZ/DW:
  - 0: CTRL (write-only; reads return 0). bit0 start, bit1 clear done/err, bit2 irq_en.
  - 1: STATUS. bit0 busy, bit1 done, bit2 err, bit3 irq_en; other bits 0.
  - 2 .. 1+NA: A words, LS word first, read/write.
  - 2+NA .. 1+2NA: B words, read/write.
  - 2+2NA .. 1+4NA: RES words, LS first, read-only.
  - Unmapped: reads return 0, writes are ignored.
- Reset: read_data=0, readdatavalid=0, waitrequest=0; A=B=RES=0; busy=done=err=irq_en=0; FSM=IDLE.
- waitrequest is combinational: busy AND (read OR write) AND addr selects A, B or RES. CTRL and STATUS accesses never stall.
- A request is accepted on an edge where (read OR write) AND NOT waitrequest.
- Read latency: exactly 1 cycle. readdatavalid=1 for one cycle, in the cycle after acceptance, with read_data driven. Back-to-back reads give one response per cycle.
- read_data holds its last value when readdatavalid=0.
- If read and write are asserted in the same cycle, the read is serviced and the write is discarded.
- FSM IDLE→RUN: on an accepted CTRL write with bit0=1 while not busy.
  - Same edge: busy←1, done←0, accumulator←0, multiplier shift reg←B, multiplicand←A (zero-extended to 2*SZ), counter←SZ-1.
- FSM RUN, each cycle: if multiplier LSB=1, accumulator += multiplicand. Then multiplicand <<1, multiplier >>1, counter decrements.
- FSM RUN→IDLE: on the edge where counter==0. RES←final accumulator, busy←0, done←1.
  - busy is high for exactly SZ cycles.
  - The first RES read may be accepted in the cycle after busy falls.
- Arithmetic is unsigned. The 2*SZ product never overflows. RES holds its value until the next completion.
- Start while busy: ignored, err←1 (sticky), operation continues unaffected.
- CTRL bit1: clears done and err on the same edge. If bit0 is also set, the start is applied after the clear (done=0, err=0, busy=1).
- CTRL bit2 is written on every CTRL write.
- Writes to A/B while busy stall until busy falls, so the operands are stable during RUN.
- Reset asserted mid-operation aborts to IDLE with all registers at their reset values. No readdatavalid is produced for a read accepted in the reset cycle.

Optional Feature:
Macro MULT_CSR_IRQ_EN.
- Defined: adds output port irq (1 bit, reset 0), registered. irq = done AND irq_en. It deasserts on the edge that clears done or irq_en.
- Undefined: no irq port; STATUS bit3 still reflects irq_en, but irq_en has no other effect.

Test Plan:
- SZ=32,DW=16: write A words 0x0003,0x0001, B words 0x0005,0x0002, CTRL=0x1 → busy for 32 cycles, then done=1. RES words 6..9 read 0x000F,0x000B,0x0002,0x0000, each with readdatavalid exactly 1 cycle after acceptance.
- A=B=0xFFFFFFFF → RES = 0xFFFFFFFE_00000001; A=0 → RES=0 with done=1 after 32 cycles.
- Read RES word 6 during busy → waitrequest=1 until busy falls, then the read is accepted and returns the new product. A read of STATUS during busy returns 0x1 with no stall.
- CTRL=0x1 during busy → STATUS reads err=1 and the result is unaffected; CTRL=0x2 → STATUS=0x0. Reads of address 15 return 0.
- rst pulsed mid-RUN at cycle 10 → next STATUS read returns 0, RES reads 0, waitrequest=0.
- With MULT_CSR_IRQ_EN: CTRL=0x5 → irq rises the cycle after done sets. CTRL=0x2 → irq falls on the next edge.
